ir_nec_tx: RTL and testbench

- NEC-format infrared transmitter; the counterpart of the IR receive path.
- Takes an 8-bit address and 8-bit command plus a start strobe.
- Serialises a full NEC frame onto the IR LED drive line: leader, 32 data bits LSB-first, stop mark.
- Used for board-to-board IR links and for loopback self-test of the on-board IR decoder.

---
 rtl/ir_nec_tx_if.sv | 11 +
 rtl/ir_nec_tx.sv | 114 +++++++++++
 tb/tb_ir_nec_tx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ir_nec_tx_if.sv
// ir_nec_tx_if: frame request (ADDR/CMD/SEND) and IR drive status (IRDA_TXD/BUSY/DONE).
interface ir_nec_tx_if;
    logic [7:0] ADDR;
    logic [7:0] CMD;
    logic       SEND;
    logic       IRDA_TXD;
    logic       BUSY;
    logic       DONE;
    modport master (output ADDR, CMD, SEND, input IRDA_TXD, BUSY, DONE);
    modport slave  (input ADDR, CMD, SEND, output IRDA_TXD, BUSY, DONE);
endinterface

// File: rtl/ir_nec_tx.sv
// ir_nec_tx: NEC IR frame transmitter (leader, 32 bits LSB-first, stop mark).
// Define IR_NEC_TX_CARRIER_EN to gate marks with a CARRIER_HALF-cycle square carrier.
module ir_nec_tx #(
    parameter int UNIT_CYCLES      = 28125,
    parameter int LEAD_MARK_UNITS  = 16,
    parameter int LEAD_SPACE_UNITS = 8
`ifdef IR_NEC_TX_CARRIER_EN
   ,parameter int CARRIER_HALF     = 658
`endif
) (
    input logic        CLOCK_50,
    input logic        RESET,
    ir_nec_tx_if.slave bus
);
    localparam int TW = $clog2(UNIT_CYCLES);
    typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK} state_t;
    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [4:0]    unit_q, unit_d, last_unit, idx_q, idx_d;
    logic [31:0]   word_q, word_d;
    logic          txd_q, txd_d, busy_q, busy_d, done_q, done_d, unit_end, mark_d;
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        unit_d    = unit_q;
        idx_d     = idx_q;
        word_d    = word_q;
        done_d    = 1'b0;
        unit_end  = tmr_q == TW'(UNIT_CYCLES - 1);
        last_unit = state_q == LEAD_MARK  ? 5'(LEAD_MARK_UNITS - 1) :
                    state_q == LEAD_SPACE ? 5'(LEAD_SPACE_UNITS - 1) :
                    (state_q == BIT_SPACE && word_q[0]) ? 5'd2 : 5'd0;
        if (state_q == IDLE) begin
            if (bus.SEND) begin
                state_d = LEAD_MARK;
                word_d  = {~bus.CMD, bus.CMD, ~bus.ADDR, bus.ADDR};
                tmr_d   = '0;
                unit_d  = '0;
                idx_d   = '0;
            end
        end else begin
            tmr_d  = unit_end ? '0 : tmr_q + TW'(1);
            unit_d = unit_end ? unit_q + 5'd1 : unit_q;
            if (unit_end && unit_q == last_unit) begin
                unit_d = '0;
                case (state_q)
                    LEAD_MARK:  state_d = LEAD_SPACE;
                    LEAD_SPACE: state_d = BIT_MARK;
                    BIT_MARK:   state_d = BIT_SPACE;
                    // word is shifted so bit 0 is always the bit being sent
                    BIT_SPACE: begin
                        state_d = idx_q == 5'd31 ? STOP_MARK : BIT_MARK;
                        idx_d   = idx_q + 5'd1;
                        word_d  = word_q >> 1;
                    end
                    STOP_MARK: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        mark_d = state_d inside {LEAD_MARK, BIT_MARK, STOP_MARK};
        busy_d = state_d != IDLE;
    end
`ifdef IR_NEC_TX_CARRIER_EN
    localparam int CW = CARRIER_HALF > 1 ? $clog2(CARRIER_HALF) : 1;
    logic [CW-1:0] car_q, car_d;
    logic          ph_q, ph_d, mark_start, car_end;
    always_comb begin
        mark_start = mark_d && !(state_q inside {LEAD_MARK, BIT_MARK, STOP_MARK});
        car_end    = car_q == CW'(CARRIER_HALF - 1);
        car_d      = (mark_start || car_end) ? '0 : car_q + CW'(1);
        ph_d       = mark_start ? 1'b1 : car_end ? ~ph_q : ph_q;
        txd_d      = mark_d && ph_d;
    end
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            car_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            car_q <= car_d;
            ph_q  <= ph_d;
        end
    end
`else
    assign txd_d = mark_d;
`endif
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            unit_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            unit_q  <= unit_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign bus.IRDA_TXD = txd_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
endmodule

// File: tb/tb_ir_nec_tx.sv
// tb_ir_nec_tx: table, random and corner-case checks of ir_nec_tx against a segment-level NEC model.
module tb_ir_nec_tx;
`ifdef IR_NEC_TX_CARRIER_EN
    localparam int U = 40;
    localparam int CH = 5;
    localparam int NRAND = 2;
`else
    localparam int U = 4;
    localparam int CH = 0;
    localparam int NRAND = 8;
`endif
    localparam int N = 121 * U;
    typedef struct {logic [7:0] a; logic [7:0] c; logic [31:0] w;} vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   cap[$];
    bit   expw[$];
    int   busy_cnt, done_at;
    logic done_txd, done_busy;
    vec_t tbl[3];
    ir_nec_tx_if bus();
    ir_nec_tx #(
        .UNIT_CYCLES(U)
`ifdef IR_NEC_TX_CARRIER_EN
       ,.CARRIER_HALF(CH)
`endif
    ) dut (.CLOCK_50(clk), .RESET(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    function automatic void add_seg(bit lvl, int len);
        for (int k = 0; k < len; k++) expw.push_back(lvl && (CH == 0 || (k / (CH == 0 ? 1 : CH)) % 2 == 0));
    endfunction
    function automatic void build_model(logic [31:0] w);
        expw.delete();
        add_seg(1'b1, 16 * U);
        add_seg(1'b0, 8 * U);
        for (int i = 0; i < 32; i++) begin
            add_seg(1'b1, U);
            add_seg(1'b0, w[i] ? 3 * U : U);
        end
        add_seg(1'b1, U);
    endfunction
`ifndef IR_NEC_TX_CARRIER_EN
    // run-length decoder: returns {valid, word}
    function automatic logic [32:0] decode();
        int runs[$];
        logic [31:0] w = '0;
        logic ok;
        int len = 0;
        for (int k = 0; k < cap.size(); k++) begin
            len++;
            if (k == cap.size() - 1 || cap[k+1] != cap[k]) begin
                runs.push_back(len);
                len = 0;
            end
        end
        if (runs.size() != 67 || cap.size() == 0 || cap[0] != 1'b1) return '0;
        ok = runs[0] == 16 * U && runs[1] == 8 * U && runs[66] == U;
        for (int i = 0; i < 32; i++) begin
            ok &= runs[2 + 2 * i] == U;
            if (runs[3 + 2 * i] == 3 * U) w[i] = 1'b1;
            else if (runs[3 + 2 * i] != U) ok = 1'b0;
        end
        return {ok, w};
    endfunction
`endif
    task automatic capture();
        cap.delete();
        busy_cnt = 0;
        done_at = -1;
        for (int k = 0; k < 2 * N; k++) begin
            @(negedge clk);
            if (bus.DONE) begin
                done_at = k;
                done_txd = bus.IRDA_TXD;
                done_busy = bus.BUSY;
                break;
            end
            cap.push_back(bus.IRDA_TXD);
            busy_cnt += int'(bus.BUSY);
        end
    endtask
    task automatic send_frame(logic [7:0] a, logic [7:0] c);
        @(posedge clk);
        #1 bus.ADDR = a; bus.CMD = c; bus.SEND = 1'b1;
        @(posedge clk);
        #1 bus.SEND = 1'b0;
        capture();
    endtask
    task automatic check_frame(string name, logic [31:0] w);
        int bad = 0;
        int first = -1;
        build_model(w);
        check({name, " done_cycle"}, done_at, N);
        check({name, " busy_cycles"}, busy_cnt, N);
        for (int k = 0; k < N; k++)
            if (k >= cap.size() || cap[k] != expw[k]) begin
                bad++;
                if (first < 0) first = k;
            end
        if (bad != 0) $display("  %s first waveform difference at cycle %0d", name, first);
        check({name, " wave_diffs"}, bad, 0);
        check({name, " txd_busy_at_done"}, {done_txd, done_busy}, 2'b00);
`ifndef IR_NEC_TX_CARRIER_EN
        check({name, " decoded"}, decode(), {1'b1, w});
`endif
        @(negedge clk);
        check({name, " done_one_cycle"}, bus.DONE, 0);
    endtask
    initial begin
        int d[$];
        int idle, cnt, busy_seen;
        logic [7:0] a, c;
        tbl[0] = '{8'h00, 8'h45, 32'hBA45FF00};
        tbl[1] = '{8'hFF, 8'h00, 32'hFF0000FF};
        tbl[2] = '{8'hA5, 8'h3C, 32'hC33C5AA5};
        bus.ADDR = '0; bus.CMD = '0; bus.SEND = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset outputs", {bus.IRDA_TXD, bus.BUSY, bus.DONE}, 3'b000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_frame(tbl[i].a, tbl[i].c);
            check_frame($sformatf("table%0d", i), tbl[i].w);
`ifdef IR_NEC_TX_CARRIER_EN
            if (i == 0) begin
                cnt = 0;
                for (int k = 0; k < 16 * U; k++) cnt += int'(cap[k] && (k == 0 || !cap[k-1]));
                check("carrier leader periods", cnt, 64);
                check("carrier first high", cap[0], 1);
                cnt = 0;
                for (int k = 16 * U; k < 24 * U; k++) cnt += int'(cap[k]);
                check("carrier space quiet", cnt, 0);
            end
`endif
        end
        for (int i = 0; i < NRAND; i++) begin
            a = 8'($urandom);
            c = 8'($urandom);
            send_frame(a, c);
            check_frame($sformatf("rand%0d", i), {~c, c, ~a, a});
        end
        // reset mid-frame, then a clean frame
        @(posedge clk);
        #1 bus.ADDR = 8'h5C; bus.CMD = 8'h77; bus.SEND = 1'b1;
        @(posedge clk);
        #1 bus.SEND = 1'b0;
        repeat (99) @(posedge clk);
        #1 check("busy before reset", bus.BUSY, 1);
        rst = 1'b1;
        #1 check("async reset outputs", {bus.IRDA_TXD, bus.BUSY, bus.DONE}, 3'b000);
        @(posedge clk);
        #1 rst = 1'b0;
        send_frame(8'h5C, 8'h77);
        check_frame("after_reset", 32'h8877A35C);
        // SEND during a frame is ignored
        fork
            send_frame(8'h12, 8'h5A);
            begin
                repeat (51) @(posedge clk);
                #1 bus.ADDR = 8'h34; bus.SEND = 1'b1;
                @(posedge clk);
                #1 bus.SEND = 1'b0;
            end
        join
        check_frame("busy_ignore", 32'hA55AED12);
        cnt = 0;
        busy_seen = 0;
        repeat (600) begin
            @(negedge clk);
            cnt += int'(bus.DONE);
            busy_seen += int'(bus.BUSY);
        end
        check("busy_ignore extra done", cnt, 0);
        check("busy_ignore extra busy", busy_seen, 0);
        // SEND held high: frames restart right after each DONE
        @(posedge clk);
        #1 bus.ADDR = 8'h81; bus.CMD = 8'h18; bus.SEND = 1'b1;
        idle = 0;
        for (int k = 0; k < 4 * N && d.size() < 3; k++) begin
            @(negedge clk);
            if (bus.DONE) d.push_back(k);
            else if (!bus.BUSY && d.size() > 0) idle++;
        end
        bus.SEND = 1'b0;
        check("b2b done count", d.size(), 3);
        if (d.size() == 3) begin
            check("b2b period 1", d[1] - d[0], N + 1);
            check("b2b period 2", d[2] - d[1], N + 1);
        end
        check("b2b idle cycles", idle, 0);
        @(negedge clk);
        check("b2b stops on release", {bus.BUSY, bus.IRDA_TXD}, 2'b00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
